uart_receiver: RTL and testbench
================================

# uart_receiver

Serial-to-parallel UART receive stage for 8N1 frames. It sits directly upstream of the UART controller and drives that controller's `recv_data`/`recv_ok` inputs. The receiver synchronises the asynchronous `rxd` pin, validates the start bit, and samples each bit at mid-period. It emits each received byte with a single-cycle strobe and flags framing errors. Clock division is counter-based; no fractional baud.

## Interface
- `CLK_PER_BIT`, default 868: clk cycles per bit (100 MHz / 115200); must be ≥ 4.
- `clk`  in  1  system clock.
- `reset`  in  1  reset, synchronous, active-high; clock clk.
- `rxd`  in  1  asynchronous serial input, idle high.
- `recv_data`  out  8  last good byte, LSB received first; held until the next good byte.
- `recv_ok`  out  1  one-cycle strobe, `recv_data` valid in the same cycle.
- `frame_error`  out  1  one-cycle strobe, stop bit sampled low.
- `busy`  out  1  high whenever state ≠ IDLE.
- `parity_error`  out  1  one-cycle strobe; present only with `UART_RX_PARITY_EN`.

## Operation
- Two-flop synchroniser on `rxd`, both flops reset to 1; the FSM sees only the synchronised value `rx_s`.
- `HALF = CLK_PER_BIT/2` (integer division).
- Counter `cnt` is `$clog2(CLK_PER_BIT)` bits wide and cleared on every state change.
- States: IDLE, START, DATA, PARITY (macro only), STOP, BREAK.
- IDLE: on `rx_s==0`, go to START.
- START: at `cnt==HALF-1`, re-check `rx_s`. If 0, go to DATA with bit index 0. If 1, treat as a glitch and return to IDLE with no strobe.
- DATA: at `cnt==CLK_PER_BIT-1`, shift `rx_s` into bit[idx] (LSB first) and increment the 3-bit index. After bit 7, go to PARITY or STOP.
- PARITY: at `cnt==CLK_PER_BIT-1`, latch the even-parity comparison result, then go to STOP.
- STOP: at `cnt==CLK_PER_BIT-1`, sample `rx_s`:
  - `rx_s==1`, parity ok: pulse `recv_ok`, load `recv_data`, go to IDLE.
  - `rx_s==1`, parity bad: pulse `parity_error`, leave `recv_data` unchanged, go to IDLE.
  - `rx_s==0`: pulse `frame_error`, drop the byte, go to BREAK. Frame error takes precedence over parity error.
- BREAK: wait for `rx_s==1`, then go to IDLE. Prevents a break condition from retriggering as start bits.
- Back-to-back frames: a start bit arriving right after a stop bit is handled. IDLE is entered mid-stop-bit, so the next falling edge is caught with a lag of at most 1 cycle.

## Timing
- Reset values: `recv_data=0`, `recv_ok=0`, `frame_error=0`, `parity_error=0`, `busy=0`, state IDLE, synchroniser flops =1.
- All outputs are registered.
- Reset mid-frame aborts the frame with no strobe; reception restarts on the next falling edge.
- Let E0 be the clk edge at which `rxd` low is first captured by sync flop 1:
  - START is entered at E0+2.
  - DATA is entered at E0+2+HALF.
  - The STOP sample occurs at E0+2+HALF+(9[+1 parity])·CLK_PER_BIT.
  - The result strobe is high during the cycle following that edge.
- At most one of `recv_ok`/`frame_error`/`parity_error` is high per frame.
- The downstream stage must not backpressure this block. Consecutive strobes are at least 10·CLK_PER_BIT cycles apart.

## Configuration
- Macro: `UART_RX_PARITY_EN`.
- Defined: the frame carries a parity bit after the data bits; even parity is required. A PARITY state is added and the `parity_error` port exists.
- Undefined: plain 8N1; no PARITY state and no `parity_error` port.

## Structure
- Package `uart_pkg`:
  - `uart_rx_state_t` enum.
  - `UART_DEFAULT_CLK_PER_BIT = 868`.
  - `UART_DATA_BITS = 8`.
- Sub-module `uart_sync2`: two-flop synchroniser with parameterised reset value. It is shared later with the transmit-side CTS input.

## Test plan
All scenarios use `CLK_PER_BIT=16`. Without parity, the strobe edge is E0+2+8+144 = E0+154; the strobe is high during the next cycle.
- Send 0x55: `recv_ok` strobe after edge E0+154 with `recv_data=0x55`; `busy` is low one cycle later.
- Send 0x00 then 0xFF back-to-back (zero idle between frames): two `recv_ok` strobes, 0x00 then 0xFF, with no `frame_error`.
- Drive a 5-cycle low glitch on `rxd`: no strobe, and state returns to IDLE by E0+11.
- Send 0xA3 with the stop bit forced low: `frame_error` pulses once; `recv_data` keeps its previous value; no new frame is accepted while `rxd` stays low for 40 cycles; the next valid 0x12 is received.
- Assert `reset` during bit 4 of 0x3C: no strobe, all outputs are 0, and a following 0x3C is received correctly.
- With `UART_RX_PARITY_EN`, send 0x07 with a wrong parity bit of 0: `parity_error` strobes at E0+170 and `recv_ok` stays 0. Then send 0x07 with a correct parity bit of 1: `recv_ok` strobes with 0x07.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types and constants for the receive path (and later the transmit path).
package uart_pkg;

    localparam int UART_DEFAULT_CLK_PER_BIT = 868;
    localparam int UART_DATA_BITS           = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } uart_rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for asynchronous single-bit inputs, with a selectable reset value.
module uart_sync2 #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receive stage: mid-bit sampling, single-cycle result strobes, framing-error detection.
// Optional even-parity bit and parity_error port when UART_RX_PARITY_EN is defined.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = UART_DEFAULT_CLK_PER_BIT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      rxd,
    output logic [UART_DATA_BITS-1:0] recv_data,
    output logic                      recv_ok,
    output logic                      frame_error,
    output logic                      busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic                      parity_error
`endif
);

    localparam int                CNT_W   = $clog2(CLK_PER_BIT);
    localparam int                HALF    = CLK_PER_BIT / 2;
    localparam logic [CNT_W-1:0]  HALF_M1 = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0]  LAST    = CNT_W'(CLK_PER_BIT - 1);

    logic                      rx_s;
    uart_rx_state_t            state, state_next;
    logic [CNT_W-1:0]          cnt, cnt_next;
    logic [2:0]                idx, idx_next;
    logic [UART_DATA_BITS-1:0] shift, shift_next;
    logic [UART_DATA_BITS-1:0] data_next;
    logic                      ok_next, ferr_next;
`ifdef UART_RX_PARITY_EN
    logic                      parity_bad, parity_bad_next;
    logic                      perr_next;
`endif

    uart_sync2 #(.RESET_VALUE(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rxd),
        .q     (rx_s)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            shift       <= '0;
            recv_data   <= '0;
            recv_ok     <= 1'b0;
            frame_error <= 1'b0;
            busy        <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bad   <= 1'b0;
            parity_error <= 1'b0;
`endif
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            idx         <= idx_next;
            shift       <= shift_next;
            recv_data   <= data_next;
            recv_ok     <= ok_next;
            frame_error <= ferr_next;
            busy        <= (state_next != IDLE);
`ifdef UART_RX_PARITY_EN
            parity_bad   <= parity_bad_next;
            parity_error <= perr_next;
`endif
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt + CNT_W'(1);
        idx_next   = idx;
        shift_next = shift;
        data_next  = recv_data;
        ok_next    = 1'b0;
        ferr_next  = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_bad_next = parity_bad;
        perr_next       = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (!rx_s) state_next = START;
            end
            START: begin
                // A start bit that has gone high again by mid-bit is a glitch.
                if (cnt == HALF_M1) begin
                    state_next = rx_s ? IDLE : DATA;
                    idx_next   = '0;
                end
            end
            DATA: begin
                if (cnt == LAST) begin
                    cnt_next        = '0;
                    shift_next[idx] = rx_s;
                    idx_next        = idx + 3'd1;
                    if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt == LAST) begin
                    parity_bad_next = ^{shift, rx_s};
                    state_next      = STOP;
                end
            end
`endif
            STOP: begin
                // Leaving mid-stop-bit lets IDLE catch a back-to-back start edge.
                if (cnt == LAST) begin
                    if (!rx_s) begin
                        ferr_next  = 1'b1;
                        state_next = BREAK;
                    end else begin
`ifdef UART_RX_PARITY_EN
                        if (parity_bad) begin
                            perr_next = 1'b1;
                        end else begin
                            ok_next   = 1'b1;
                            data_next = shift;
                        end
`else
                        ok_next   = 1'b1;
                        data_next = shift;
`endif
                        state_next = IDLE;
                    end
                end
            end
            BREAK: begin
                if (rx_s) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (state_next != state) cnt_next = '0;
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard testbench for uart_receiver at CLK_PER_BIT=16; parity scenarios need UART_RX_PARITY_EN.
module tb_uart_receiver;

    localparam int CPB      = 16;
    localparam int LAT      = 154;
    localparam int LAT_PAR  = 170;
    localparam logic [2:0] K_OK   = 3'b001;
    localparam logic [2:0] K_FERR = 3'b010;
    localparam logic [2:0] K_PERR = 3'b100;

    typedef struct {
        logic [2:0] kind;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       rxd;
    logic [7:0] recv_data;
    logic       recv_ok;
    logic       frame_error;
    logic       busy;
    logic       perr_obs;

    exp_t       sb[$];
    int         cyc;
    int         checks;
    int         failures;
    logic [7:0] last_good;

`ifdef UART_RX_PARITY_EN
    logic parity_error;
    assign perr_obs = parity_error;
`else
    assign perr_obs = 1'b0;
`endif

    uart_receiver #(.CLK_PER_BIT(CPB)) dut (
        .clk         (clk),
        .reset       (reset),
        .rxd         (rxd),
        .recv_data   (recv_data),
        .recv_ok     (recv_ok),
        .frame_error (frame_error),
        .busy        (busy)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_error(parity_error)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drives a frame bit by bit starting at a falling clock edge; the first start-bit capture is cyc+1.
    task automatic applyStimulus(input logic [7:0] data, input logic stop_bit, input logic use_par,
                                 input logic par_bit, input int nbits, input logic [2:0] kind);
        logic [10:0] bits;
        int          total;
        exp_t        e;
        total = use_par ? 11 : 10;
        bits  = use_par ? {stop_bit, par_bit, data, 1'b0} : {1'b0, stop_bit, data, 1'b0};
        if (kind != 3'b000) begin
            e.kind = kind;
            e.data = (kind == K_OK) ? data : last_good;
            e.cyc  = cyc + 1 + (use_par ? LAT_PAR : LAT);
            sb.push_back(e);
            if (kind == K_OK) last_good = data;
        end
        for (int i = 0; i < total && i < nbits; i++) begin
            rxd = bits[i];
            repeat (CPB) @(negedge clk);
        end
    endtask

    // Monitor: pops the scoreboard on every result strobe, independent of stimulus.
    initial begin
        exp_t       e;
        logic [2:0] obs;
        forever begin
            @(negedge clk);
            obs = {perr_obs, frame_error, recv_ok};
            if (!reset && obs != 3'b000) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_strobe", {29'd0, obs}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("strobe_kind", {29'd0, obs}, {29'd0, e.kind});
                    checkOutput("strobe_cycle", cyc, e.cyc);
                    checkOutput("recv_data", {24'd0, recv_data}, {24'd0, e.data});
                    @(negedge clk);
                    checkOutput("strobe_width", {29'd0, perr_obs, frame_error, recv_ok}, 32'd0);
                    if (e.kind != K_FERR) checkOutput("busy_after_strobe", {31'd0, busy}, 32'd0);
                end
            end
        end
    end

    initial begin
        repeat (20000) @(posedge clk);
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int e0;
        cyc       = 0;
        checks    = 0;
        failures  = 0;
        last_good = 8'h00;
        reset     = 1'b1;
        rxd       = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("reset_recv_data", {24'd0, recv_data}, 32'd0);
        checkOutput("reset_recv_ok", {31'd0, recv_ok}, 32'd0);
        checkOutput("reset_frame_error", {31'd0, frame_error}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        repeat (4) @(negedge clk);

        $display("[TB] single frame 0x55");
        applyStimulus(8'h55, 1'b1, 1'b0, 1'b0, 11, K_OK);
        repeat (5) @(negedge clk);

        $display("[TB] back-to-back 0x00, 0xFF");
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b0, 11, K_OK);
        applyStimulus(8'hFF, 1'b1, 1'b0, 1'b0, 11, K_OK);
        repeat (5) @(negedge clk);

        $display("[TB] 5-cycle glitch");
        rxd = 1'b0;
        e0  = cyc + 1;
        repeat (5) @(negedge clk);
        rxd = 1'b1;
        @(negedge clk);
        checkOutput("glitch_busy_start", {31'd0, busy}, 32'd1);
        while (cyc < e0 + 11) @(negedge clk);
        checkOutput("glitch_busy_idle", {31'd0, busy}, 32'd0);
        repeat (20) @(negedge clk);

        $display("[TB] framing error on 0xA3 then break");
        applyStimulus(8'hA3, 1'b0, 1'b0, 1'b0, 11, K_FERR);
        repeat (40) @(negedge clk);
        checkOutput("break_busy", {31'd0, busy}, 32'd1);
        rxd = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("break_released", {31'd0, busy}, 32'd0);
        checkOutput("break_data_held", {24'd0, recv_data}, 32'hFF);
        applyStimulus(8'h12, 1'b1, 1'b0, 1'b0, 11, K_OK);
        repeat (5) @(negedge clk);

        $display("[TB] reset during bit 4 of 0x3C");
        applyStimulus(8'h3C, 1'b1, 1'b0, 1'b0, 5, 3'b000);
        rxd = 1'b1;
        repeat (8) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("midreset_recv_data", {24'd0, recv_data}, 32'd0);
        checkOutput("midreset_recv_ok", {31'd0, recv_ok}, 32'd0);
        checkOutput("midreset_frame_error", {31'd0, frame_error}, 32'd0);
        checkOutput("midreset_busy", {31'd0, busy}, 32'd0);
        reset     = 1'b0;
        last_good = 8'h00;
        repeat (5) @(negedge clk);
        applyStimulus(8'h3C, 1'b1, 1'b0, 1'b0, 11, K_OK);
        repeat (5) @(negedge clk);

`ifdef UART_RX_PARITY_EN
        $display("[TB] parity 0x07 wrong then right");
        applyStimulus(8'h07, 1'b1, 1'b1, 1'b0, 12, K_PERR);
        repeat (5) @(negedge clk);
        applyStimulus(8'h07, 1'b1, 1'b1, 1'b1, 12, K_OK);
        repeat (5) @(negedge clk);
`endif

        checkOutput("scoreboard_drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
